// File: rtl/sync_counter.sv
// Dual free-running event-duration counters with synchronized enables and an edge-triggered snapshot.
// Optional build macro SYNC_COUNTER_SATURATE_EN: counters stop at all-ones instead of wrapping.
module sync_counter #(
  parameter int unsigned COUNTER_A_BITS = 32,
  parameter int unsigned OFFSET_A_BITS  = 1,
  parameter int unsigned COUNTER_B_BITS = 11,
  parameter int unsigned OFFSET_B_BITS  = 0
) (
  input  logic                      axi_clk,
  input  logic                      reset,
  input  logic                      snapshot,
  input  logic                      enable_a,
  input  logic                      enable_b,
  output logic [COUNTER_A_BITS-1:0] counter_a_result,
  output logic [COUNTER_B_BITS-1:0] counter_b_result
);

  localparam int unsigned CNT_A_W = COUNTER_A_BITS + OFFSET_A_BITS;
  localparam int unsigned CNT_B_W = COUNTER_B_BITS + OFFSET_B_BITS;

  logic en_a_s1_q, en_a_s1_d, en_a_s2_q, en_a_s2_d;
  logic en_b_s1_q, en_b_s1_d, en_b_s2_q, en_b_s2_d;
  logic snap_s1_q, snap_s1_d, snap_s2_q, snap_s2_d, snap_s3_q, snap_s3_d;
  logic [CNT_A_W-1:0]        cnt_a_q, cnt_a_d;
  logic [CNT_B_W-1:0]        cnt_b_q, cnt_b_d;
  logic [COUNTER_A_BITS-1:0] res_a_q, res_a_d;
  logic [COUNTER_B_BITS-1:0] res_b_q, res_b_d;
  logic                      snap_rise_c;

  assign snap_rise_c = snap_s2_q & ~snap_s3_q;

  always_comb begin
    en_a_s1_d = enable_a;
    en_a_s2_d = en_a_s1_q;
    en_b_s1_d = enable_b;
    en_b_s2_d = en_b_s1_q;
    snap_s1_d = snapshot;
    snap_s2_d = snap_s1_q;
    snap_s3_d = snap_s2_q;
    cnt_a_d   = cnt_a_q;
    cnt_b_d   = cnt_b_q;
    res_a_d   = res_a_q;
    res_b_d   = res_b_q;

`ifdef SYNC_COUNTER_SATURATE_EN
    if (en_a_s2_q && !(&cnt_a_q)) cnt_a_d = cnt_a_q + CNT_A_W'(1);
    if (en_b_s2_q && !(&cnt_b_q)) cnt_b_d = cnt_b_q + CNT_B_W'(1);
`else
    if (en_a_s2_q) cnt_a_d = cnt_a_q + CNT_A_W'(1);
    if (en_b_s2_q) cnt_b_d = cnt_b_q + CNT_B_W'(1);
`endif

    // Capture uses the pre-increment counts; prescaler LSBs are dropped.
    if (snap_rise_c) begin
      res_a_d = COUNTER_A_BITS'(cnt_a_q >> OFFSET_A_BITS);
      res_b_d = COUNTER_B_BITS'(cnt_b_q >> OFFSET_B_BITS);
    end
  end

  always_ff @(posedge axi_clk) begin
    if (!reset) begin
      en_a_s1_q <= 1'b0;
      en_a_s2_q <= 1'b0;
      en_b_s1_q <= 1'b0;
      en_b_s2_q <= 1'b0;
      snap_s1_q <= 1'b0;
      snap_s2_q <= 1'b0;
      snap_s3_q <= 1'b0;
      cnt_a_q   <= '0;
      cnt_b_q   <= '0;
      res_a_q   <= '0;
      res_b_q   <= '0;
    end else begin
      en_a_s1_q <= en_a_s1_d;
      en_a_s2_q <= en_a_s2_d;
      en_b_s1_q <= en_b_s1_d;
      en_b_s2_q <= en_b_s2_d;
      snap_s1_q <= snap_s1_d;
      snap_s2_q <= snap_s2_d;
      snap_s3_q <= snap_s3_d;
      cnt_a_q   <= cnt_a_d;
      cnt_b_q   <= cnt_b_d;
      res_a_q   <= res_a_d;
      res_b_q   <= res_b_d;
    end
  end

  assign counter_a_result = res_a_q;
  assign counter_b_result = res_b_q;

endmodule

// File: tb/tb_sync_counter.sv
// Bench for sync_counter: default-parameter DUT plus a 3-bit counter-B DUT, checked against a cycle model.
module tb_sync_counter;

  localparam int A_BITS  = 32;
  localparam int A_OFF   = 1;
  localparam int B_BITS  = 11;
  localparam int B_OFF   = 0;
  localparam int BS_BITS = 3;

  logic              axi_clk = 1'b0;
  logic              reset = 1'b0;
  logic              snapshot = 1'b0;
  logic              enable_a = 1'b0;
  logic              enable_b = 1'b0;
  logic [A_BITS-1:0] res_a;
  logic [B_BITS-1:0] res_b;
  logic [A_BITS-1:0] sres_a;
  logic [BS_BITS-1:0] sres_b;

  int n_cmp = 0;
  int n_fail = 0;
  bit chk_on = 1'b0;

  always #5 axi_clk = ~axi_clk;

  sync_counter u_dut (
    .axi_clk(axi_clk), .reset(reset), .snapshot(snapshot),
    .enable_a(enable_a), .enable_b(enable_b),
    .counter_a_result(res_a), .counter_b_result(res_b)
  );

  sync_counter #(.COUNTER_B_BITS(BS_BITS), .OFFSET_B_BITS(0)) u_dut_s (
    .axi_clk(axi_clk), .reset(reset), .snapshot(snapshot),
    .enable_a(enable_a), .enable_b(enable_b),
    .counter_a_result(sres_a), .counter_b_result(sres_b)
  );

  // Reference model: counts and captures in plain integers, inputs delayed by sample history.
  longint unsigned m_cnt_a = 0, m_cnt_b = 0, m_cnt_bs = 0;
  longint unsigned m_res_a = 0, m_res_b = 0, m_res_bs = 0;
  bit ea_h1 = 0, ea_h2 = 0, eb_h1 = 0, eb_h2 = 0;
  bit sn_h1 = 0, sn_h2 = 0, sn_h3 = 0;

  function automatic longint unsigned bump(longint unsigned v, int w);
    longint unsigned mx;
    mx = (longint'(1) << w) - 1;
`ifdef SYNC_COUNTER_SATURATE_EN
    return (v == mx) ? mx : v + 1;
`else
    return (v + 1) & mx;
`endif
  endfunction

  always @(posedge axi_clk) begin
    if (!reset) begin
      m_cnt_a = 0; m_cnt_b = 0; m_cnt_bs = 0;
      m_res_a = 0; m_res_b = 0; m_res_bs = 0;
      ea_h1 = 0; ea_h2 = 0; eb_h1 = 0; eb_h2 = 0;
      sn_h1 = 0; sn_h2 = 0; sn_h3 = 0;
    end else begin
      if (sn_h2 && !sn_h3) begin
        m_res_a  = m_cnt_a >> A_OFF;
        m_res_b  = m_cnt_b >> B_OFF;
        m_res_bs = m_cnt_bs;
      end
      if (ea_h2) m_cnt_a = bump(m_cnt_a, A_BITS + A_OFF);
      if (eb_h2) begin
        m_cnt_b  = bump(m_cnt_b, B_BITS + B_OFF);
        m_cnt_bs = bump(m_cnt_bs, BS_BITS);
      end
      ea_h2 = ea_h1; ea_h1 = enable_a;
      eb_h2 = eb_h1; eb_h1 = enable_b;
      sn_h3 = sn_h2; sn_h2 = sn_h1; sn_h1 = snapshot;
    end
  end

  task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge axi_clk) begin
    if (chk_on) begin
      check("model_res_a",   longint'(res_a),  m_res_a);
      check("model_res_b",   longint'(res_b),  m_res_b);
      check("model_s_res_a", longint'(sres_a), m_res_a);
      check("model_s_res_b", longint'(sres_b), m_res_bs);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge axi_clk);
  endtask

  task automatic pulse_snap();
    snapshot = 1'b1;
    step(1);
    snapshot = 1'b0;
    step(3);
  endtask

  longint unsigned r1, r2;

  initial begin
    // 1: reset state
    step(3);
    check("reset_a", longint'(res_a), 0);
    check("reset_b", longint'(res_b), 0);
    check("reset_s_b", longint'(sres_b), 0);
    reset = 1'b1;
    chk_on = 1'b1;
    pulse_snap();
    check("idle_snap_a", longint'(res_a), 0);
    check("idle_snap_b", longint'(res_b), 0);

    // 2: count A for 10 cycles
    enable_a = 1'b1; step(10); enable_a = 1'b0; step(4);
    pulse_snap();
    check("count_a_res", longint'(res_a), 5);
    check("count_a_b0",  longint'(res_b), 0);

    // 3: count B for 7, then hold snapshot high while B keeps counting
    enable_b = 1'b1; step(7); enable_b = 1'b0; step(4);
    pulse_snap();
    check("count_b_res", longint'(res_b), 7);
    check("count_b_s",   longint'(sres_b), 7);
    check("count_b_a",   longint'(res_a), 5);
    enable_b = 1'b1; snapshot = 1'b1;
    step(3);
    check("hold_first", longint'(res_b), 7);
    step(17);
    check("hold_after", longint'(res_b), 7);
    snapshot = 1'b0; enable_b = 1'b0; step(4);

    // 4: running capture 16 cycles apart
    enable_a = 1'b1; step(3);
    pulse_snap();
    r1 = longint'(res_a);
    step(12);
    pulse_snap();
    r2 = longint'(res_a);
    check("run_diff", r2 - r1, 8);
    enable_a = 1'b0; step(4);

    // 5: reset in the middle of counting
    enable_a = 1'b1; enable_b = 1'b1; step(50);
    reset = 1'b0; step(1); reset = 1'b1;
    check("midrst_a", longint'(res_a), 0);
    check("midrst_b", longint'(res_b), 0);
    step(6);
    enable_a = 1'b0; enable_b = 1'b0; step(4);
    pulse_snap();
    check("restart_a",   longint'(res_a), 3);
    check("restart_b",   longint'(res_b), 6);
    check("restart_s_b", longint'(sres_b), 6);

    // 6: wrap / saturate on the 3-bit counter
    reset = 1'b0; step(1); reset = 1'b1;
    enable_b = 1'b1; step(10); enable_b = 1'b0; step(4);
    pulse_snap();
    check("wide_b_10", longint'(res_b), 10);
`ifdef SYNC_COUNTER_SATURATE_EN
    check("small_b_sat", longint'(sres_b), 7);
`else
    check("small_b_wrap", longint'(sres_b), 2);
`endif

    // Randomized traffic, checked every cycle by the model
    for (int i = 0; i < 3000; i++) begin
      enable_a = ($urandom_range(0, 3) != 0);
      enable_b = ($urandom_range(0, 1) != 0);
      if ($urandom_range(0, 3) == 0) snapshot = ~snapshot;
      reset = ($urandom_range(0, 299) != 0);
      step(1);
    end
    reset = 1'b1; enable_a = 1'b0; enable_b = 1'b0; snapshot = 1'b0;
    step(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
